custom_ip_reg_arb: RTL

CUSTOM_IP_REG_ARB -- requirements
Module: custom_ip_reg_arb

---
 rtl/custom_ip_reg_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/custom_ip_reg_arb.sv
// Two-requester arbiter in front of a three-register IP block: IDLE -> ACCESS -> RESP per transaction.
// Define CUSTOM_IP_REG_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module custom_ip_reg_arb #(
    parameter int unsigned DW = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [3:0]        addr_i,
    input  logic [2*DW-1:0]   wdata_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DW-1:0]     rdata_o,
    output logic              err_o,
    output logic [2:0]        reg_en_o,
    output logic [DW-1:0]     reg_data_o,
    input  logic [3*DW-1:0]   reg_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic            win_d;
    logic            win_q;
    logic            we_q;
    logic [1:0]      addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            addr_ok;

    always_comb addr_ok = (addr_q != 2'd3);

`ifdef CUSTOM_IP_REG_ARB_FIXED_PRIO_EN
    always_comb win_d = ~req_i[0];
`else
    logic last_q;

    // With both requesting, the one not granted last wins; otherwise the lone requester.
    always_comb begin
        if (req_i == 2'b11) win_d = ~last_q;
        else                win_d = req_i[1];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                            last_q <= 1'b1;
        else if (state_q == IDLE && |req_i)     last_q <= win_d;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_i) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && |req_i) begin
                win_q   <= win_d;
                we_q    <= we_i[win_d];
                addr_q  <= addr_i[win_d*2 +: 2];
                wdata_q <= wdata_i[win_d*DW +: DW];
            end
            if (state_q == ACCESS) begin
                if (!we_q) begin
                    case (addr_q)
                        2'd0:    rdata_q <= reg_rdata_i[0*DW +: DW];
                        2'd1:    rdata_q <= reg_rdata_i[1*DW +: DW];
                        2'd2:    rdata_q <= reg_rdata_i[2*DW +: DW];
                        default: rdata_q <= '0;
                    endcase
                end else begin
                    rdata_q <= '0;
                end
            end
        end
    end

    always_comb begin
        gnt_o      = '0;
        rvalid_o   = '0;
        rdata_o    = '0;
        err_o      = 1'b0;
        reg_en_o   = '0;
        reg_data_o = '0;
        case (state_q)
            ACCESS: begin
                gnt_o = win_q ? 2'b10 : 2'b01;
                if (we_q && addr_ok) begin
                    reg_en_o   = 3'b001 << addr_q;
                    reg_data_o = wdata_q;
                end
            end
            RESP: begin
                rvalid_o = win_q ? 2'b10 : 2'b01;
                rdata_o  = rdata_q;
                err_o    = ~addr_ok;
            end
            default: ;
        endcase
    end

endmodule
